// File: rtl/data_mem_bridge.sv
// Line-fill / writeback engine: 256-bit cache line port <-> 32-bit word memory port.
// Optional critical-word-first fill order: define DATA_MEM_BRIDGE_CWF_EN.
module data_mem_bridge #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0] req_wb_addr,
  input  logic [255:0]          req_wdata,
  output logic [255:0]          resp_rdata,
  output logic                  resp_valid,
  output logic                  busy,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  input  logic                  ram_ack
);
  localparam int TW = ADDR_WIDTH - 5;

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_e;

  state_e               state_q, state_d;
  logic [2:0]           k_q, k_d;
  logic [TW-1:0]        fa_q, fa_d, wa_q, wa_d;
  logic [7:0][31:0]     wl_q, wl_d, rl_q, rl_d;
  logic                 rd_q, rd_d;
  logic                 ram_req_q, ram_req_d, ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]          ram_wdata_q, ram_wdata_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [2:0]           s_in, s_cur, w_cur, w_nxt, k_inc;
  logic                 accept;
  logic                 unused_bits;

  assign accept = (state_q == IDLE) && (req_read || req_write);

`ifdef DATA_MEM_BRIDGE_CWF_EN
  logic [2:0] s_q;
  always_ff @(posedge CLK) begin
    if (RST)         s_q <= 3'd0;
    else if (accept) s_q <= req_addr[4:2];
  end
  assign s_in        = req_addr[4:2];
  assign s_cur       = s_q;
  assign unused_bits = ^{req_addr[1:0], req_wb_addr[4:0]};
`else
  assign s_in        = 3'd0;
  assign s_cur       = 3'd0;
  assign unused_bits = ^{req_addr[4:0], req_wb_addr[4:0]};
`endif

  // Fill word index rotates from the start word; 3-bit adds wrap 7->0.
  assign k_inc = k_q + 3'd1;
  assign w_cur = s_cur + k_q;
  assign w_nxt = s_cur + k_inc;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    fa_d         = fa_q;
    wa_d         = wa_q;
    wl_d         = wl_q;
    rl_d         = rl_q;
    rd_d         = rd_q;
    ram_req_d    = ram_req_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    resp_valid_d = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        fa_d      = req_addr[ADDR_WIDTH-1:5];
        wa_d      = req_wb_addr[ADDR_WIDTH-1:5];
        wl_d      = req_wdata;
        rd_d      = req_read;
        k_d       = 3'd0;
        ram_req_d = 1'b1;
        if (req_write) begin
          state_d     = WB;
          ram_we_d    = 1'b1;
          ram_addr_d  = {req_wb_addr[ADDR_WIDTH-1:5], 3'd0, 2'b00};
          ram_wdata_d = req_wdata[31:0];
        end else begin
          state_d    = FILL;
          ram_we_d   = 1'b0;
          ram_addr_d = {req_addr[ADDR_WIDTH-1:5], s_in, 2'b00};
        end
      end
      WB: if (ram_ack) begin
        k_d = k_inc;
        if (k_q == 3'd7) begin
          ram_we_d = 1'b0;
          if (rd_q) begin
            // ram_req stays high straight into the fill phase
            state_d    = FILL;
            ram_addr_d = {fa_q, s_cur, 2'b00};
          end else begin
            state_d      = DONE;
            ram_req_d    = 1'b0;
            resp_valid_d = 1'b1;
          end
        end else begin
          ram_addr_d  = {wa_q, k_inc, 2'b00};
          ram_wdata_d = wl_q[k_inc];
        end
      end
      FILL: if (ram_ack) begin
        rl_d[w_cur] = ram_rdata;
        k_d         = k_inc;
        if (k_q == 3'd7) begin
          state_d      = DONE;
          ram_req_d    = 1'b0;
          resp_valid_d = 1'b1;
        end else begin
          ram_addr_d = {fa_q, w_nxt, 2'b00};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      k_q          <= 3'd0;
      fa_q         <= '0;
      wa_q         <= '0;
      wl_q         <= '0;
      rl_q         <= '0;
      rd_q         <= 1'b0;
      ram_req_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      fa_q         <= fa_d;
      wa_q         <= wa_d;
      wl_q         <= wl_d;
      rl_q         <= rl_d;
      rd_q         <= rd_d;
      ram_req_q    <= ram_req_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign resp_rdata = rl_q;
  assign resp_valid = resp_valid_q;
  assign busy       = (state_q != IDLE);
  assign ram_req    = ram_req_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
endmodule

// File: tb/tb_data_mem_bridge.sv
// Scoreboard bench for data_mem_bridge: expected beats/lines queued at request time.
module tb_data_mem_bridge;
  logic         CLK = 1'b0;
  logic         RST, req_read, req_write, ram_ack;
  logic [31:0]  req_addr, req_wb_addr, ram_addr, ram_wdata, ram_rdata;
  logic [255:0] req_wdata, resp_rdata;
  logic         resp_valid, busy, ram_req, ram_we;

  data_mem_bridge #(.ADDR_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wb_addr(req_wb_addr), .req_wdata(req_wdata),
    .resp_rdata(resp_rdata), .resp_valid(resp_valid), .busy(busy),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  always #5 CLK = ~CLK;

  // memory model: every word reads back as its own address
  assign ram_rdata = ram_addr;

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } beat_t;
  typedef struct packed { logic [255:0] line; logic [31:0] lat; } resp_t;

  beat_t        beat_q[$];
  resp_t        resp_q[$];
  int           checks = 0, fails = 0, cyc = 0, t0 = 0;
  logic [255:0] line_m = '0;
  logic         pend = 1'b0;
  logic [32:0]  pend_v = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    beat_t b;
    resp_t r;
    if (pend) chk("stall_hold", {ram_req, ram_we, ram_addr}, {1'b1, pend_v});
    pend   <= ram_req && !ram_ack;
    pend_v <= {ram_we, ram_addr};
    if (ram_req && ram_ack) begin
      if (beat_q.size() == 0) chk("beat_extra", {1'b1, ram_addr}, 0);
      else begin
        b = beat_q.pop_front();
        chk("beat_we_addr", {ram_we, ram_addr}, {b.we, b.addr});
        if (b.we) chk("beat_wdata", ram_wdata, b.wdata);
      end
    end
    if (busy && !resp_valid) chk("req_continuous", ram_req, 1);
    if (resp_valid) begin
      chk("busy_at_done", busy, 1);
      if (resp_q.size() == 0) chk("resp_extra", 1, 0);
      else begin
        r = resp_q.pop_front();
        chk("resp_line", resp_rdata, r.line);
        chk("resp_cycle", cyc - t0, r.lat);
      end
    end
  end

  task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wa,
                     input logic [255:0] wd, input int waits);
    logic [2:0] s, w;
    if (wr)
      for (int k = 0; k < 8; k++)
        beat_q.push_back({1'b1, wa[31:5], 3'(k), 2'b00, wd[32*k +: 32]});
    if (rd) begin
`ifdef DATA_MEM_BRIDGE_CWF_EN
      s = a[4:2];
`else
      s = 3'd0;
`endif
      for (int k = 0; k < 8; k++) begin
        w = s + 3'(k);
        beat_q.push_back({1'b0, a[31:5], w, 2'b00, 32'h0});
      end
      for (int i = 0; i < 8; i++) line_m[32*i +: 32] = {a[31:5], 3'(i), 2'b00};
    end
    resp_q.push_back({line_m, 32'(8 * (int'(rd) + int'(wr)) + waits)});
    req_read = rd; req_write = wr; req_addr = a; req_wb_addr = wa; req_wdata = wd;
    step();
    t0 = cyc;
    req_read = 1'b0; req_write = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((busy || resp_q.size() != 0) && n < max) begin step(); n++; end
    if (n >= max) chk("timeout", 0, 1);
    chk("beats_left", beat_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [255:0] wd1, wd2;
    for (int i = 0; i < 8; i++) begin
      wd1[32*i +: 32] = 32'hA0 + i;
      wd2[32*i +: 32] = 32'h5500_0000 + 32'(i * 17);
    end
    RST = 1'b1; req_read = 0; req_write = 0; req_addr = 0; req_wb_addr = 0;
    req_wdata = 0; ram_ack = 1'b1;
    repeat (3) step();
    chk("rst_ram_req", ram_req, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    RST = 1'b0;
    step();

    txn(1, 0, 32'h0000_1040, 32'h0, '0, 0);          // fill only
    wait_idle(40);
    txn(1, 1, 32'h0000_3000, 32'h0000_2000, wd1, 0); // writeback + fill
    wait_idle(60);
    txn(0, 1, 32'h0, 32'h0000_2400, wd2, 0);         // writeback only, line unchanged
    wait_idle(40);

    txn(1, 0, 32'h0000_1040, 32'h0, '0, 3);          // stall fill beat 2 for 3 cycles
    for (int c = 2; c <= 6; c++) begin
      step();
      ram_ack = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
    end
    wait_idle(40);

    txn(1, 0, 32'h0000_1058, 32'h0, '0, 0);          // start word 6
    wait_idle(40);

    txn(1, 0, 32'h0000_5000, 32'h0, '0, 0);          // reset mid-fill in cycle 4
    step(); step(); step();
    RST = 1'b1;
    step();
    chk("abort_ram_req", ram_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_resp_rdata", resp_rdata, 0);
    chk("abort_resp_valid", resp_valid, 0);
    beat_q.delete(); resp_q.delete(); line_m = '0;
    RST = 1'b0;
    repeat (12) step();
    txn(1, 0, 32'h0000_1040, 32'h0, '0, 0);
    wait_idle(40);

    txn(1, 0, 32'h0000_6000, 32'h0, '0, 0);          // requests while busy are ignored
    req_read = 1'b1; req_write = 1'b1; req_addr = 32'h7000; req_wb_addr = 32'h7400;
    req_wdata = wd2;
    repeat (4) step();
    req_read = 1'b0; req_write = 1'b0;
    wait_idle(40);
    repeat (5) step();
    chk("idle_after_ignore", busy, 0);
    chk("no_extra_beats", beat_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
